// File: rtl/imem_prefetch.sv
// rtl/imem_prefetch.sv - instruction prefetch queue between handshaked instruction memory and the core
//
// Issues sequential word fetches ahead of the core and buffers up to DEPTH
// {instr, pc} entries. The queue head is presented to the core. A redirect
// flushes the queue, drops in-flight data and restarts fetch at a new PC.
//
// Parameters:
//   DEPTH        queue entries (power of two, 2..16)
//   RESET_PC     first fetch address after reset
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   mem_req      read request to instruction memory (registered)
//   mem_addr     word address of the request (registered, low bits 0)
//   mem_ack      memory returns mem_rdata this cycle (only while mem_req=1)
//   mem_rdata    instruction word, valid with mem_ack
//   redirect     flush queue and restart fetch at redirect_pc
//   redirect_pc  new fetch PC, bits [1:0] ignored
//   instr        queue head instruction
//   instr_pc     PC of the queue head
//   instr_valid  queue non-empty
//   instr_take   core consumes the head this cycle
//   flush_count  redirects that discarded work (only with IMEM_PREFETCH_STATS_EN)
//
// Optional feature macro: IMEM_PREFETCH_STATS_EN adds flush_count.

module imem_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_take
`ifdef IMEM_PREFETCH_STATS_EN
    ,
    output logic [15:0] flush_count
`endif
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];

    logic            push;
    logic            pop;
    logic [AW:0]     next_count;
    logic            slot_free;
    logic            outstanding;
    logic [31:0]     redirect_al;
    logic [31:0]     fetch_pc_inc;
    logic            unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    always_comb begin
        pop          = instr_take && (count != '0);
        // Data arriving in DISCARD or alongside a redirect is never stored.
        push         = (state == S_REQ) && mem_ack && !redirect;
        next_count   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        // A new request is only issued when a slot is left for its data.
        slot_free    = next_count < DEPTH_C;
        outstanding  = mem_req && !mem_ack;
        redirect_al  = {redirect_pc[31:2], 2'b00};
        fetch_pc_inc = fetch_pc + 32'd4;
    end

    // Head is gated so an empty queue never shows stale data.
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? instr_mem[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]    : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fetch_pc <= redirect_al;
            mem_req  <= 1'b1;
            if (outstanding) begin
                // Memory still owes us a beat for the old address: keep
                // the request (and its address) up and drop the data.
                state <= S_DISCARD;
            end else begin
                state    <= S_REQ;
                mem_addr <= redirect_al;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count;

            case (state)
                S_IDLE: begin
                    if (slot_free) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        fetch_pc <= fetch_pc_inc;
                        mem_addr <= fetch_pc_inc;
                        if (!slot_free) begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        state    <= S_REQ;
                        mem_addr <= fetch_pc;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_PREFETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_count <= '0;
        end else if (redirect && (instr_valid || outstanding) && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/imem_prefetch.md
# imem_prefetch

Instruction prefetch queue between a slow, handshaked instruction memory and the single-cycle MIPS core's instruction input. It issues sequential word fetches ahead of the core, buffers up to DEPTH instructions with their PCs, and presents the queue head to the core. A redirect (taken branch/jump) flushes the queue, discards any in-flight data, and restarts fetch at a new PC.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  word address of request; low 2 bits always 0
- mem_ack  in  1  memory returns mem_rdata this cycle; sampled only while mem_req=1
- mem_rdata  in  32  instruction word, valid when mem_ack=1
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced to 0)
- instr  out  32  queue head instruction
- instr_pc  out  32  PC of queue head
- instr_valid  out  1  queue non-empty
- instr_take  in  1  core consumes head this cycle
- flush_count  out  16  only with IMEM_PREFETCH_STATS_EN (see Configuration)

## Operation
- FIFO of DEPTH entries {instr, pc}; read/write pointers wrap modulo DEPTH; count 0..DEPTH.
- fetch_pc register: address of next request; +4 per accepted ack, wraps 32'hFFFF_FFFC -> 0.
- States: IDLE (no request), REQ (mem_req=1, mem_addr=fetch_pc), DISCARD (mem_req=1 held with stale address, data to be dropped).
- Issue rule: enter/stay in REQ when count + (accepted-this-cycle ? 1 : 0) - (pop-this-cycle ? 1 : 0) < DEPTH, i.e. a slot is reserved for every outstanding request; FIFO never overflows.
- REQ: mem_addr stable until mem_ack. On ack: push {mem_rdata, fetch_pc}, fetch_pc += 4; stay REQ if slot available, else IDLE.
- IDLE -> REQ when a slot frees.
- Pop: instr_take && instr_valid removes head; instr_take while empty ignored.
- Push and pop in same cycle: both occur, count unchanged.
- Redirect (any state): FIFO cleared, fetch_pc <= {redirect_pc[31:2],2'b00}; instr_take and any same-cycle ack data dropped. If a request is outstanding and not acked this cycle -> DISCARD; else -> REQ at new PC next cycle.
- DISCARD: hold mem_req=1 and old mem_addr until ack; drop data; then REQ at fetch_pc. Redirect in DISCARD updates fetch_pc only, stays DISCARD.
- Only one request outstanding at any time.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, count=0, state IDLE, flush_count=0.
- First cycle after reset release: mem_req=1, mem_addr=RESET_PC.
- Ack in cycle N -> entry visible (instr_valid=1) cycle N+1. instr/instr_pc/instr_valid driven from registered FIFO state only; no combinational path from mem_rdata or mem_ack.
- Zero-wait memory (ack in first req cycle): mem_req stays high, mem_addr advances +4 per cycle, sustained 1 instr/cycle while core takes every cycle.
- Redirect in cycle N: instr_valid=0 in N+1; new-PC request at N+1 (no outstanding) or cycle after the stale ack (DISCARD).
- Reset asserted mid-operation clears immediately; outstanding request abandoned (mem_req drops asynchronously).
- mem_req/mem_addr registered outputs.

## Configuration
- IMEM_PREFETCH_STATS_EN defined: port flush_count present; increments by 1 for every redirect that clears a non-empty FIFO or enters DISCARD; saturates at 16'hFFFF; cleared by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, zero-wait memory, instr_take=1 always -> mem_addr 0,4,8,... consecutive cycles; instr_pc 0,4,8 starting one cycle after first ack; instr_valid stays 1.
- Memory acks after 3 wait cycles, core never takes, DEPTH=4 -> exactly 4 acks accepted (pc 0..12), then mem_req=0; one take -> mem_req=1 at addr 16 next cycle.
- Redirect to 32'h0000_0103 with 2 entries queued, no outstanding -> instr_valid=0 next cycle, next mem_addr=32'h0000_0100.
- Redirect while request for 0x8 outstanding, ack 2 cycles later with 32'hDEADBEEF -> mem_addr held 0x8 until ack, DEADBEEF never appears on instr, then request at redirect_pc.
- Redirect and instr_take and mem_ack same cycle -> FIFO empty next cycle, ack data dropped, fetch restarts at redirect_pc; with IMEM_PREFETCH_STATS_EN flush_count increments by 1.
- Reset asserted mid-stream with 3 entries queued -> all outputs return to reset values immediately; fetch restarts at RESET_PC after release.
